// File: rtl/noc_ctrl_pkg.sv
// Shared types for the NoC input-port control path: flit type encoding,
// per-input-VC state, and the default output-VC count.
package noc_ctrl_pkg;

    localparam int CN_DEFAULT = 5;

    localparam logic [1:0] HEAD_CODE = 2'b00;
    localparam logic [1:0] BODY_CODE = 2'b01;
    localparam logic [1:0] TAIL_CODE = 2'b10;

    typedef enum logic [1:0] {
        HEAD = HEAD_CODE,
        BODY = BODY_CODE,
        TAIL = TAIL_CODE
    } flit_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        LOCKED = 2'b10
    } ivc_state_t;

    // True when the 2-bit front-flit code matches the given flit type.
    function automatic logic flit_is(input logic [1:0] code, input flit_type_t t);
        return (code == t);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the first requester at or after
// the pointer. The pointer only moves when told which requester finally won,
// so a selection that is still waiting for its downstream grant keeps
// priority where it was.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         adv,
    input  logic [N-1:0] adv_gnt,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             found_s;

    // Pick the first requester scanning upward from the pointer, with wrap.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int j = 0; j < N; j++) begin
                if (!found_s && req[j] && (j == ((int'(ptr_q) + off) % N))) begin
                    gnt[j]  = 1'b1;
                    found_s = 1'b1;
                end else begin
                    gnt[j]  = gnt[j];
                end
            end
        end
    end

    // Next pointer: one past the winner when a grant completes.
    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            for (int j = 0; j < N; j++) begin
                if (adv_gnt[j]) begin
                    ptr_d = PTR_W'((j + 1) % N);
                end else begin
                    ptr_d = ptr_d;
                end
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vc_input_controller_chk.sv
// Protocol checks for the input-VC controller: flits may only leave an IVC
// that owns an output VC (locked, or being granted this cycle), and at most
// one IVC may be waiting on the VC allocator at a time.
module vc_input_controller_chk #(
    parameter int NIVC = 2
) (
    input logic            clk,
    input logic            rstn,
    input logic            flit_fire,
    input logic [NIVC-1:0] fire_ivc,
    input logic [NIVC-1:0] fire_ok,
    input logic [NIVC-1:0] in_req
);

    a_fire_legal: assert property (@(posedge clk) disable iff (!rstn)
        flit_fire |-> (|(fire_ivc & fire_ok)));

    a_single_req: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(in_req));

endmodule

// File: rtl/vc_input_controller.sv
// Per-input-port controller for NIVC input virtual channels sharing one
// VC-allocator request port. Each IVC walks IDLE -> REQ -> LOCKED -> IDLE;
// a round-robin arbiter chooses which waiting head may request, the request
// is frozen until granted, and locks are held per IVC until the tail leaves.
// Optionally head requests are gated on downstream credit, with starvation
// statistics kept in hardware.
module vc_input_controller
    import noc_ctrl_pkg::*;
#(
    parameter int NIVC   = 2,
    parameter int CN     = CN_DEFAULT,
    parameter int FC_EN  = 0,
    parameter int FCPL   = 16,
    parameter int CRD_W  = 32,
    parameter int STAT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NIVC-1:0]      fifo_empty,
    input  logic [2*NIVC-1:0]    flit_type,
    input  logic [CN*NIVC-1:0]   candidate_out_vc,
    output logic [CN-1:0]        req_vc,
    output logic [NIVC-1:0]      req_ivc,
    input  logic [CN-1:0]        sel_out_vc,
    input  logic                 vc_granted,
    output logic [CN*NIVC-1:0]   sel_xb_vc,
    input  logic                 flit_fire,
    input  logic [NIVC-1:0]      fire_ivc,
    input  logic [CRD_W-1:0]     credit_cnt,
    output logic                 crd_starve,
    output logic [STAT_W-1:0]    starve_events,
    output logic [STAT_W-1:0]    starve_cycles
);

    // A head needs room for a whole packet minus the two flits already
    // accounted for by the pipeline.
    localparam logic [CRD_W-1:0] CRD_TH = CRD_W'((FCPL >= 2) ? (FCPL - 2) : 0);

    ivc_state_t          state_q   [NIVC];
    ivc_state_t          state_d   [NIVC];
    logic [CN-1:0]       out_vc_q  [NIVC];
    logic [CN-1:0]       out_vc_d  [NIVC];
    logic [CN-1:0]       req_vc_q, req_vc_d;
    logic [NIVC-1:0]     req_ivc_q, req_ivc_d;
    logic                crd_starve_q, crd_starve_d;
    logic [STAT_W-1:0]   starve_events_q, starve_events_d;
    logic [STAT_W-1:0]   starve_cycles_q, starve_cycles_d;

    logic                credit_ok_s;
    logic                in_req_s;
    logic                blocked_s;
    logic [NIVC-1:0]     waiting_s;
    logic [NIVC-1:0]     locked_s;
    logic [NIVC-1:0]     req_st_s;
    logic [NIVC-1:0]     arb_req_s;
    logic [NIVC-1:0]     arb_gnt_s;
    logic [NIVC-1:0]     fire_ok_s;

    // Qualify each IVC: waiting head, lock/request status, credit gate.
    always_comb begin
        waiting_s = '0;
        locked_s  = '0;
        req_st_s  = '0;
        credit_ok_s = (FC_EN == 0) || (credit_cnt >= CRD_TH);
        for (int i = 0; i < NIVC; i++) begin
            waiting_s[i] = (state_q[i] == IDLE) && !fifo_empty[i]
                           && flit_is(flit_type[2*i +: 2], HEAD);
            locked_s[i]  = (state_q[i] == LOCKED);
            req_st_s[i]  = (state_q[i] == REQ);
        end
        in_req_s  = |req_ivc_q;
        arb_req_s = in_req_s ? '0 : (waiting_s & {NIVC{credit_ok_s}});
        blocked_s = (FC_EN != 0) && (|waiting_s) && !credit_ok_s;
        fire_ok_s = locked_s | (req_st_s & {NIVC{vc_granted}});
    end

    rr_arbiter #(.N(NIVC)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (arb_req_s),
        .adv     (in_req_s & vc_granted),
        .adv_gnt (req_ivc_q),
        .gnt     (arb_gnt_s)
    );

    // Per-IVC state transitions and output-VC lock capture/release.
    always_comb begin
        for (int i = 0; i < NIVC; i++) begin
            state_d[i]  = state_q[i];
            out_vc_d[i] = out_vc_q[i];
            case (state_q[i])
                IDLE: begin
                    if (arb_gnt_s[i]) begin
                        state_d[i] = REQ;
                    end else begin
                        state_d[i] = IDLE;
                    end
                end
                REQ: begin
                    if (vc_granted) begin
                        state_d[i]  = LOCKED;
                        out_vc_d[i] = sel_out_vc;
                    end else begin
                        state_d[i]  = REQ;
                    end
                end
                LOCKED: begin
                    if (flit_fire && fire_ivc[i] && flit_is(flit_type[2*i +: 2], TAIL)) begin
                        state_d[i]  = IDLE;
                        out_vc_d[i] = '0;
                    end else begin
                        state_d[i]  = LOCKED;
                    end
                end
                default: begin
                    state_d[i]  = IDLE;
                    out_vc_d[i] = '0;
                end
            endcase
        end
    end

    // Request port: load on selection, freeze until granted, clear otherwise.
    always_comb begin
        req_vc_d  = '0;
        req_ivc_d = '0;
        if (in_req_s) begin
            if (vc_granted) begin
                req_vc_d  = '0;
                req_ivc_d = '0;
            end else begin
                req_vc_d  = req_vc_q;
                req_ivc_d = req_ivc_q;
            end
        end else begin
            req_ivc_d = arb_gnt_s;
            for (int i = 0; i < NIVC; i++) begin
                req_vc_d = req_vc_d | (candidate_out_vc[i*CN +: CN] & {CN{arb_gnt_s[i]}});
            end
        end
    end

    // Credit-starvation flag and saturating statistics.
    always_comb begin
        crd_starve_d = blocked_s;
        if (blocked_s && (starve_cycles_q != {STAT_W{1'b1}})) begin
            starve_cycles_d = starve_cycles_q + STAT_W'(1);
        end else begin
            starve_cycles_d = starve_cycles_q;
        end
        if (blocked_s && !crd_starve_q && (starve_events_q != {STAT_W{1'b1}})) begin
            starve_events_d = starve_events_q + STAT_W'(1);
        end else begin
            starve_events_d = starve_events_q;
        end
    end

    // Crossbar select: held lock, or same-cycle pass-through of a fresh grant
    // so the head can leave in its grant cycle.
    always_comb begin
        sel_xb_vc = '0;
        for (int i = 0; i < NIVC; i++) begin
            if (locked_s[i]) begin
                sel_xb_vc[i*CN +: CN] = out_vc_q[i];
            end else if (req_st_s[i] && vc_granted) begin
                sel_xb_vc[i*CN +: CN] = sel_out_vc;
            end else begin
                sel_xb_vc[i*CN +: CN] = '0;
            end
        end
    end

    // All controller state; reset drops every lock and pending request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NIVC; i++) begin
                state_q[i]  <= IDLE;
                out_vc_q[i] <= '0;
            end
            req_vc_q        <= '0;
            req_ivc_q       <= '0;
            crd_starve_q    <= 1'b0;
            starve_events_q <= '0;
            starve_cycles_q <= '0;
        end else begin
            for (int i = 0; i < NIVC; i++) begin
                state_q[i]  <= state_d[i];
                out_vc_q[i] <= out_vc_d[i];
            end
            req_vc_q        <= req_vc_d;
            req_ivc_q       <= req_ivc_d;
            crd_starve_q    <= crd_starve_d;
            starve_events_q <= starve_events_d;
            starve_cycles_q <= starve_cycles_d;
        end
    end

    assign req_vc        = req_vc_q;
    assign req_ivc       = req_ivc_q;
    assign crd_starve    = crd_starve_q;
    assign starve_events = starve_events_q;
    assign starve_cycles = starve_cycles_q;

    vc_input_controller_chk #(.NIVC(NIVC)) u_chk (
        .clk       (clk),
        .rstn      (rstn),
        .flit_fire (flit_fire),
        .fire_ivc  (fire_ivc),
        .fire_ok   (fire_ok_s),
        .in_req    (req_st_s)
    );

endmodule

// File: tb/tb_vc_input_controller.sv
// Directed bench for vc_input_controller (NIVC=2, CN=5, FC_EN=1, FCPL=16).
// Expected requests go into a scoreboard queue when a head is presented and
// are popped when the DUT raises req_ivc.
module tb_vc_input_controller;
    import noc_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0] ivc;
        logic [4:0] vc;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [1:0]  fifo_empty;
    logic [3:0]  flit_type;
    logic [9:0]  candidate_out_vc;
    logic [4:0]  req_vc;
    logic [1:0]  req_ivc;
    logic [4:0]  sel_out_vc;
    logic        vc_granted;
    logic [9:0]  sel_xb_vc;
    logic        flit_fire;
    logic [1:0]  fire_ivc;
    logic [31:0] credit_cnt;
    logic        crd_starve;
    logic [15:0] starve_events;
    logic [15:0] starve_cycles;

    int   n_total = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    vc_input_controller #(
        .NIVC(2), .CN(5), .FC_EN(1), .FCPL(16), .CRD_W(32), .STAT_W(16)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .fifo_empty       (fifo_empty),
        .flit_type        (flit_type),
        .candidate_out_vc (candidate_out_vc),
        .req_vc           (req_vc),
        .req_ivc          (req_ivc),
        .sel_out_vc       (sel_out_vc),
        .vc_granted       (vc_granted),
        .sel_xb_vc        (sel_xb_vc),
        .flit_fire        (flit_fire),
        .fire_ivc         (fire_ivc),
        .credit_cnt       (credit_cnt),
        .crd_starve       (crd_starve),
        .starve_events    (starve_events),
        .starve_cycles    (starve_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ft(input int i, input logic [1:0] v);
        flit_type[2*i +: 2] = v;
    endtask

    task automatic set_cand(input int i, input logic [4:0] v);
        candidate_out_vc[5*i +: 5] = v;
    endtask

    task automatic idle_inputs();
        fifo_empty       = 2'b11;
        flit_type        = 4'b0000;
        candidate_out_vc = 10'd0;
        sel_out_vc       = 5'd0;
        vc_granted       = 1'b0;
        flit_fire        = 1'b0;
        fire_ivc         = 2'b00;
        credit_cnt       = 32'd100;
    endtask

    task automatic do_reset();
        idle_inputs();
        sb_q.delete();
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
    endtask

    task automatic wait_req(output int lat);
        exp_t e;
        lat = 0;
        while ((req_ivc == 2'b00) && (lat < 20)) begin
            tick();
            lat++;
        end
        n_total++;
        assert (req_ivc !== 2'b00) else begin
            n_fail++;
            $error("FAIL req_timeout: observed req_ivc %0h expected nonzero", req_ivc);
        end
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("req_ivc", 32'(req_ivc), 32'(e.ivc));
            chk("req_vc", 32'(req_vc), 32'(e.vc));
        end
    endtask

    task automatic grant_head(input logic [4:0] sel, input logic [1:0] ivc);
        vc_granted = 1'b1;
        sel_out_vc = sel;
        flit_fire  = 1'b1;
        fire_ivc   = ivc;
        tick();
        vc_granted = 1'b0;
        sel_out_vc = 5'd0;
        flit_fire  = 1'b0;
        fire_ivc   = 2'b00;
    endtask

    task automatic fire_tail(input int i);
        set_ft(i, TAIL);
        flit_fire = 1'b1;
        fire_ivc  = (i == 0) ? 2'b01 : 2'b10;
        tick();
        flit_fire = 1'b0;
        fire_ivc  = 2'b00;
    endtask

    initial begin
        int         lat;
        logic [1:0] wv;
        logic [4:0] cv;

        // Reset state
        rstn = 1'b0;
        idle_inputs();
        #12;
        chk("rst_req_vc", 32'(req_vc), 32'd0);
        chk("rst_req_ivc", 32'(req_ivc), 32'd0);
        chk("rst_sel_xb", 32'(sel_xb_vc), 32'd0);
        chk("rst_starve", 32'({crd_starve, starve_events, starve_cycles}), 32'd0);
        rstn = 1'b1;

        // Single packet on IVC0
        fifo_empty = 2'b10;
        set_ft(0, HEAD);
        set_cand(0, 5'b00100);
        sb_q.push_back('{ivc: 2'b01, vc: 5'b00100});
        wait_req(lat);
        chk("s1_latency", 32'(lat), 32'd1);
        vc_granted = 1'b1;
        sel_out_vc = 5'b00100;
        flit_fire  = 1'b1;
        fire_ivc   = 2'b01;
        #1;
        chk("s1_xb_grant", 32'(sel_xb_vc), 32'h004);
        tick();
        vc_granted = 1'b0;
        sel_out_vc = 5'd0;
        chk("s1_req_clear", 32'({req_ivc, req_vc}), 32'd0);
        chk("s1_xb_locked", 32'(sel_xb_vc), 32'h004);
        set_ft(0, BODY);
        tick();
        chk("s1_xb_body", 32'(sel_xb_vc), 32'h004);
        set_ft(0, TAIL);
        #1;
        chk("s1_xb_tail", 32'(sel_xb_vc), 32'h004);
        tick();
        flit_fire  = 1'b0;
        fire_ivc   = 2'b00;
        fifo_empty = 2'b11;
        chk("s1_xb_after", 32'(sel_xb_vc), 32'd0);

        // Round-robin between two IVCs with continuous heads
        tick();
        do_reset();
        fifo_empty = 2'b00;
        set_ft(0, HEAD);
        set_ft(1, HEAD);
        set_cand(0, 5'b00001);
        set_cand(1, 5'b00010);
        for (int k = 0; k < 4; k++) begin
            wv = ((k % 2) == 0) ? 2'b01 : 2'b10;
            cv = ((k % 2) == 0) ? 5'b00001 : 5'b00010;
            sb_q.push_back('{ivc: wv, vc: cv});
            wait_req(lat);
            grant_head(cv, wv);
            fire_tail(k % 2);
            set_ft(k % 2, HEAD);
        end
        idle_inputs();

        // Grant on IVC0 concurrent with IVC1 tail fire
        tick();
        do_reset();
        fifo_empty = 2'b01;
        set_ft(1, HEAD);
        set_cand(1, 5'b01000);
        sb_q.push_back('{ivc: 2'b10, vc: 5'b01000});
        wait_req(lat);
        grant_head(5'b01000, 2'b10);
        set_ft(1, BODY);
        fifo_empty = 2'b00;
        set_ft(0, HEAD);
        set_cand(0, 5'b00001);
        sb_q.push_back('{ivc: 2'b01, vc: 5'b00001});
        wait_req(lat);
        vc_granted = 1'b1;
        sel_out_vc = 5'b00001;
        flit_fire  = 1'b1;
        fire_ivc   = 2'b10;
        set_ft(1, TAIL);
        #1;
        chk("s3_xb_both", 32'(sel_xb_vc), 32'h101);
        tick();
        vc_granted = 1'b0;
        sel_out_vc = 5'd0;
        flit_fire  = 1'b0;
        fire_ivc   = 2'b00;
        fifo_empty = 2'b10;
        chk("s3_xb_after", 32'(sel_xb_vc), 32'h001);
        chk("s3_req_idle", 32'(req_ivc), 32'd0);
        flit_fire = 1'b1;
        fire_ivc  = 2'b01;
        tick();
        fire_tail(0);
        fifo_empty = 2'b11;
        chk("s3_xb_done", 32'(sel_xb_vc), 32'd0);

        // Credit starvation
        tick();
        do_reset();
        credit_cnt = 32'd13;
        fifo_empty = 2'b10;
        set_ft(0, HEAD);
        set_cand(0, 5'b00100);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("s4_no_req", 32'(req_ivc), 32'd0);
        end
        chk("s4_starve", 32'(crd_starve), 32'd1);
        chk("s4_cycles", 32'(starve_cycles), 32'd5);
        chk("s4_events", 32'(starve_events), 32'd1);
        sb_q.push_back('{ivc: 2'b01, vc: 5'b00100});
        credit_cnt = 32'd14;
        wait_req(lat);
        chk("s4_latency", 32'(lat), 32'd1);
        chk("s4_starve_clr", 32'(crd_starve), 32'd0);
        chk("s4_cycles_hold", 32'(starve_cycles), 32'd5);
        grant_head(5'b00100, 2'b01);
        fire_tail(0);
        set_ft(0, HEAD);
        credit_cnt = 32'd13;
        tick();
        tick();
        chk("s4_events2", 32'(starve_events), 32'd2);
        chk("s4_cycles2", 32'(starve_cycles), 32'd7);
        idle_inputs();

        // Credit drop while a request is pending
        tick();
        credit_cnt = 32'd20;
        fifo_empty = 2'b10;
        set_ft(0, HEAD);
        set_cand(0, 5'b10000);
        sb_q.push_back('{ivc: 2'b01, vc: 5'b10000});
        wait_req(lat);
        credit_cnt = 32'd3;
        set_cand(0, 5'b00001);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s5_hold", 32'({req_ivc, req_vc}), 32'({2'b01, 5'b10000}));
        end
        grant_head(5'b10000, 2'b01);
        chk("s5_req_clear", 32'({req_ivc, req_vc}), 32'd0);
        fire_tail(0);
        idle_inputs();

        // Async reset mid-traffic
        tick();
        do_reset();
        fifo_empty = 2'b10;
        set_ft(0, HEAD);
        set_cand(0, 5'b00100);
        sb_q.push_back('{ivc: 2'b01, vc: 5'b00100});
        wait_req(lat);
        grant_head(5'b00100, 2'b01);
        set_ft(0, BODY);
        fifo_empty = 2'b00;
        set_ft(1, HEAD);
        set_cand(1, 5'b00010);
        sb_q.push_back('{ivc: 2'b10, vc: 5'b00010});
        wait_req(lat);
        chk("s6_pre_xb", 32'(sel_xb_vc), 32'h004);
        rstn = 1'b0;
        #1;
        chk("s6_rst_req", 32'({req_ivc, req_vc}), 32'd0);
        chk("s6_rst_xb", 32'(sel_xb_vc), 32'd0);
        chk("s6_rst_stat", 32'({crd_starve, starve_events, starve_cycles}), 32'd0);
        set_ft(0, HEAD);
        set_cand(0, 5'b00001);
        rstn = 1'b1;
        sb_q.push_back('{ivc: 2'b01, vc: 5'b00001});
        wait_req(lat);
        chk("s6_latency", 32'(lat), 32'd1);
        chk("s6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

// File: doc/vc_input_controller.md
Name: vc_input_controller

Overview:
- Per-input-port controller for a NoC router with NIVC input virtual channels sharing one port to the VC allocator.
- Sits between the per-IVC input buffers and route calculators on one side, and the vc_allocator and crossbar on the other.
- Generalises the single-VC gather controller with:
  - multiple input VCs and round-robin request arbitration;
  - per-IVC output-VC locks;
  - request hold-until-grant;
  - optional whole-packet credit gating;
  - credit-starvation statistics in hardware instead of simulation logging.

Parameters:
- NIVC, 2, number of input VCs on this port (>=1).
- CN, `CN, number of output VCs (one-hot width).
- FC_EN, 0, 1 = gate head requests on downstream credit (FC start port).
- FCPL, 16, FC packet length in flits; a head may request only if credit_cnt >= FCPL-2.
- CRD_W, 32, credit counter width.
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- fifo_empty  in  NIVC  per-IVC buffer empty.
- flit_type  in  2*NIVC  per-IVC front-flit type (`HEAD/`BODY/`TAIL).
- candidate_out_vc  in  CN*NIVC  per-IVC candidate output VCs from the route calculator.
- req_vc  out  CN  request to vc_allocator.
- req_ivc  out  NIVC  one-hot IVC owning req_vc; 0 when idle.
- sel_out_vc  in  CN  one-hot granted output VC.
- vc_granted  in  1  grant for the current request.
- sel_xb_vc  out  CN*NIVC  per-IVC output VC to the crossbar.
- flit_fire  in  1  a flit leaves this port this cycle.
- fire_ivc  in  NIVC  one-hot IVC of the fired flit.
- credit_cnt  in  CRD_W  downstream credits.
- crd_starve  out  1  a head is currently blocked by credit.
- starve_events  out  STAT_W  saturating count of starvation onsets.
- starve_cycles  out  STAT_W  saturating count of blocked cycles.

Behaviour:
- Reset (async, rstn=0):
  - all IVCs go to IDLE; arbiter pointer = 0;
  - req_vc, req_ivc, sel_xb_vc, crd_starve, starve_events and starve_cycles all = 0;
  - reset asserted mid-packet discards all locks and any pending request.
- eligible[i] = IVC i in IDLE, fifo_empty[i]=0, flit_type[i]==`HEAD, and (FC_EN==0 or credit_cnt >= FCPL-2). The comparison is unsigned.
- Per-IVC state machine:
  - IDLE -> REQ: IVC i is selected by the arbiter.
  - REQ -> LOCKED: vc_granted=1. On the same edge, out_vc[i] <= sel_out_vc.
  - LOCKED -> IDLE: flit_fire & fire_ivc[i] & flit_type[i]==`TAIL. On the same edge, out_vc[i] <= 0.
- Arbitration:
  - at most one IVC is in REQ at a time;
  - when no IVC is in REQ, a round-robin choice among eligible IVCs is registered (1-cycle latency eligible -> req);
  - after a grant, the pointer advances to winner+1 mod NIVC.
- Request stability:
  - while in REQ, req_vc = candidate_out_vc of that IVC, registered at selection, and req_ivc = its one-hot;
  - both are held constant until vc_granted, even if credit drops;
  - req_vc = 0 in every other case.
- Crossbar select:
  - sel_xb_vc[i] = out_vc[i] when LOCKED;
  - = sel_out_vc when in REQ and vc_granted (zero-latency pass-through, so the head may fire in the grant cycle);
  - = 0 otherwise.
- Independent locks: several IVCs may be LOCKED at once. A tail fire on one IVC never affects the others. A tail fire and a grant on different IVCs in the same cycle are both honoured.
- flit_fire for an IVC not in LOCKED (and not in its grant cycle) is a protocol error: assertion only, no state change.
- Starvation (FC_EN=1 only; otherwise outputs are tied 0):
  - blocked = some IVC is IDLE, non-empty and showing a head, with credit_cnt < FCPL-2;
  - crd_starve is registered blocked;
  - starve_cycles += 1 per blocked cycle;
  - starve_events += 1 on each 0->1 transition of blocked;
  - both counters saturate at all-ones.
- Packets are at least 2 flits (HEAD ... TAIL).

Decomposition:
- Package noc_ctrl_pkg: flit_type_t enum (HEAD/BODY/TAIL) and ivc_state_t enum (IDLE/REQ/LOCKED), wrapping the existing `CN/`HEAD/`TAIL params.svh macros.
- Sub-module rr_arbiter #(N): request vector in, one-hot grant out, advance input, registered pointer.

Test Plan:
- NIVC=2, IVC0 head, candidate 5'b00100, grant next cycle with sel_out_vc=5'b00100 -> req_ivc=01 one cycle after eligibility; sel_xb_vc[0]=00100 in the grant cycle and held until the tail fire; 0 the cycle after.
- Both IVCs hold heads continuously; grant each request; 4 packets -> req_ivc order 01,10,01,10.
- IVC1 LOCKED while IVC0 is granted in the same cycle that IVC1's tail fires -> IVC0 becomes LOCKED, IVC1 goes IDLE, neither lock corrupted.
- FC_EN=1, FCPL=16, credit_cnt=13 with a head waiting for 5 cycles, then credit=14 -> no req during the 5 cycles; crd_starve=1; starve_cycles=5; starve_events=1; req follows one cycle after credit=14.
- Credit drops from 20 to 3 while in REQ -> req_vc unchanged until grant.
- rstn pulsed low while IVC0 LOCKED and IVC1 in REQ -> all outputs 0 immediately (async); after release, the next head requests normally.
